// File: rtl/decrypt_core.sv
// decrypt_core: sequential Baby-Kyber decryption for N=4, K=2, Q=17.
// Computes m' = v - s^T*u in Z17[x]/(x^4+1) with one shared multiply-accumulate
// step per cycle (32 steps), then decodes m' into a 4-bit message.
// The result is presented through a start/busy/valid handshake with a fixed
// 33-cycle latency from the capture edge.
module decrypt_core #(
    parameter int DATA_W = 32,
    parameter int COEF_W = 5
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    input  logic signed [1:0][1:0][3:0][DATA_W-1:0]  ciphertext,
    input  logic signed [1:0][3:0][DATA_W-1:0]       secret_key,
    output logic [31:0]                              message,
    output logic                                     busy,
    output logic                                     valid
);

    localparam int Q      = 17;
    localparam int QHALF  = 9;
    localparam int N      = 4;
    localparam int K      = 2;
    // Decode window [DEC_LO, DEC_HI] is centred on QHALF: 5..12 for Q=17.
    localparam int DEC_LO = (QHALF + 1) / 2;
    localparam int DEC_HI = Q - DEC_LO;
    localparam int PROD_W = 2 * COEF_W;
    // acc - p reaches -256 and acc + p reaches 272, so 11 signed bits suffice.
    localparam int SUM_W  = PROD_W + 1;

    localparam logic signed [DATA_W-1:0] Q_D = DATA_W'(Q);
    localparam logic signed [SUM_W-1:0]  Q_S = SUM_W'(Q);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MAC    = 2'd1,
        DECODE = 2'd2
    } state_t;

    state_t               state;
    logic [4:0]           cnt;
    logic [COEF_W-1:0]    u_q   [K][N];
    logic [COEF_W-1:0]    s_q   [K][N];
    logic [COEF_W-1:0]    acc   [N];

    logic                 mi;
    logic [1:0]           mj;
    logic [1:0]           mk;
    logic [COEF_W-1:0]    s_sel;
    logic [COEF_W-1:0]    u_sel;
    logic [PROD_W-1:0]    prod;
    logic [2:0]           jk;
    logic                 wrap;
    logic [1:0]           idx;
    logic signed [SUM_W-1:0] acc_s;
    logic signed [SUM_W-1:0] prod_s;
    logic signed [SUM_W-1:0] sum;
    logic [COEF_W-1:0]    acc_nxt;

    // The [1][1] slot of the ciphertext carries no data for this parameter set.
    wire unused_ct = ^ciphertext[1][1];

    // Reduce an arbitrary signed input coefficient into [0, Q-1].
    function automatic logic [COEF_W-1:0] reduce_in(input logic signed [DATA_W-1:0] x);
        logic signed [DATA_W-1:0] r;
        r = x % Q_D;
        if (r < 0) begin
            r = r + Q_D;
        end
        return r[COEF_W-1:0];
    endfunction

    // Reduce a signed accumulator sum into [0, Q-1]; the single shared reducer.
    function automatic logic [COEF_W-1:0] mod_q(input logic signed [SUM_W-1:0] x);
        logic signed [SUM_W-1:0] r;
        r = x % Q_S;
        if (r < 0) begin
            r = r + Q_S;
        end
        return r[COEF_W-1:0];
    endfunction

    // A coefficient decodes to 1 when it lies near Q/2 rather than near 0.
    function automatic logic dec_bit(input logic [COEF_W-1:0] a);
        return (a >= COEF_W'(DEC_LO)) && (a <= COEF_W'(DEC_HI));
    endfunction

    // Counter fields: i selects the polynomial pair, j the key term, k the u term.
    assign mi = cnt[4];
    assign mj = cnt[3:2];
    assign mk = cnt[1:0];

    // One MAC step: p = s[i][j]*u[i][k]; subtract into x^(j+k), or add when x^4 = -1 wraps.
    always_comb begin
        s_sel   = s_q[mi][mj];
        u_sel   = u_q[mi][mk];
        prod    = PROD_W'(s_sel) * PROD_W'(u_sel);
        jk      = {1'b0, mj} + {1'b0, mk};
        wrap    = jk[2];
        idx     = jk[1:0];
        acc_s   = $signed(SUM_W'(acc[idx]));
        prod_s  = $signed(SUM_W'(prod));
        sum     = wrap ? (acc_s + prod_s) : (acc_s - prod_s);
        acc_nxt = mod_q(sum);
    end

    // Control FSM with capture, accumulate and decode; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            message <= '0;
            for (int n = 0; n < N; n++) begin
                acc[n] <= '0;
            end
            for (int i = 0; i < K; i++) begin
                for (int n = 0; n < N; n++) begin
                    u_q[i][n] <= '0;
                    s_q[i][n] <= '0;
                end
            end
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < K; i++) begin
                            for (int n = 0; n < N; n++) begin
                                u_q[i][n] <= reduce_in($signed(ciphertext[0][i][n]));
                                s_q[i][n] <= reduce_in($signed(secret_key[i][n]));
                            end
                        end
                        for (int n = 0; n < N; n++) begin
                            acc[n] <= reduce_in($signed(ciphertext[1][0][n]));
                        end
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc[idx] <= acc_nxt;
                    cnt      <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    // Coefficient n carries message bit N-1-n.
                    for (int n = 0; n < N; n++) begin
                        message[N-1-n] <= dec_bit(acc[n]);
                    end
                    message[31:N] <= '0;
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decrypt_core.sv
// Directed testbench for decrypt_core: table of ciphertext/key vectors with
// hand-computed messages, plus handshake and mid-run reset sequences.
module tb_decrypt_core;

    typedef logic signed [3:0][31:0] poly_t;

    typedef struct {
        poly_t       u0;
        poly_t       u1;
        poly_t       v;
        poly_t       junk;
        poly_t       s0;
        poly_t       s1;
        logic [31:0] exp_msg;
    } vec_t;

    localparam int NV = 9;

    logic                             clk;
    logic                             rst_n;
    logic                             start;
    logic signed [1:0][1:0][3:0][31:0] ciphertext;
    logic signed [1:0][3:0][31:0]      secret_key;
    logic [31:0]                      message;
    logic                             busy;
    logic                             valid;

    int n_vec   = 0;
    int n_bad   = 0;
    int overlap = 0;

    vec_t tbl [NV];

    decrypt_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ciphertext (ciphertext),
        .secret_key (secret_key),
        .message    (message),
        .busy       (busy),
        .valid      (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic poly_t pl(input int c0, input int c1, input int c2, input int c3);
        poly_t p;
        p[0] = c0;
        p[1] = c1;
        p[2] = c2;
        p[3] = c3;
        return p;
    endfunction

    function automatic vec_t mk(input poly_t u0, input poly_t u1, input poly_t v,
                                input poly_t s0, input poly_t s1, input logic [31:0] m);
        vec_t r;
        r.u0 = u0; r.u1 = u1; r.v = v; r.junk = pl(0, 0, 0, 0);
        r.s0 = s0; r.s1 = s1; r.exp_msg = m;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ciphertext[0][0] = v.u0;
        ciphertext[0][1] = v.u1;
        ciphertext[1][0] = v.v;
        ciphertext[1][1] = v.junk;
        secret_key[0]    = v.s0;
        secret_key[1]    = v.s1;
    endtask

    // Waits (bounded) for valid; lat counts edges after the capture edge.
    task automatic wait_valid(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy && valid) overlap++;
            if (valid) break;
            if (busy) bcnt++;
        end
    endtask

    task automatic run_op(input vec_t v, input int t);
        int lat;
        int bcnt;
        @(negedge clk);
        drive(v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check($sformatf("v%0d busy_at_E0", t), {31'd0, busy}, 32'd1);
        wait_valid(lat, bcnt);
        check($sformatf("v%0d latency", t), lat, 33);
        check($sformatf("v%0d busy_cycles", t), bcnt + 1, 33);
        check($sformatf("v%0d message", t), message, v.exp_msg);
        check($sformatf("v%0d busy_at_valid", t), {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check($sformatf("v%0d valid_drop", t), {31'd0, valid}, 32'd0);
    endtask

    initial begin
        int lat;
        int bcnt;
        bit seen;

        // Zero key: message comes straight from v.
        tbl[0] = mk(pl(0,0,0,0), pl(0,0,0,0), pl(8,0,8,0),   pl(0,0,0,0),  pl(0,0,0,0), 32'hA);
        tbl[1] = mk(pl(0,0,0,0), pl(0,0,0,0), pl(4,5,12,13), pl(0,0,0,0),  pl(0,0,0,0), 32'h6);
        // s0 = x^3, u0 = x: product x^4 = -1, so m'0 = 4 + 1 = 5.
        tbl[2] = mk(pl(0,1,0,0), pl(0,0,0,0), pl(4,0,0,0),   pl(0,0,0,1),  pl(0,0,0,0), 32'h8);
        // s0 = -1, u0 = 2: m'0 = 3 + 2 = 5; then v0 = 20 reduces to 3.
        tbl[3] = mk(pl(2,0,0,0), pl(0,0,0,0), pl(3,0,0,0),   pl(-1,0,0,0), pl(0,0,0,0), 32'h8);
        tbl[4] = mk(pl(2,0,0,0), pl(0,0,0,0), pl(20,0,0,0),  pl(-1,0,0,0), pl(0,0,0,0), 32'h8);
        // v = [-1,35,9,16] reduces to [16,1,9,16]: only coefficient 2 is in range.
        tbl[5] = mk(pl(0,0,0,0), pl(0,0,0,0), pl(-1,35,9,16), pl(0,0,0,0), pl(0,0,0,0), 32'h2);
        // (1+x+x^2+x^3)^2 = [-2,0,2,4]; m' = [3,5,14,0] - that = [5,5,12,13].
        tbl[6] = mk(pl(1,1,1,1), pl(0,0,0,0), pl(3,5,14,0),  pl(1,1,1,1),  pl(0,0,0,0), 32'hE);
        tbl[6].junk = pl(7,7,7,7);
        // Second pair: s1 = x, u1 = 3x^3 gives -3; m'0 = 2 + 3 = 5.
        tbl[7] = mk(pl(0,0,0,0), pl(0,0,0,3), pl(2,0,0,0),   pl(0,0,0,0),  pl(0,1,0,0), 32'h8);
        // u0 = 35 reduces to 1: m'0 = 6 - 1 = 5.
        tbl[8] = mk(pl(35,0,0,0), pl(0,0,0,0), pl(6,0,0,0),  pl(1,0,0,0),  pl(0,0,0,0), 32'h8);

        rst_n = 1'b0;
        start = 1'b0;
        drive(tbl[0]);
        repeat (2) @(posedge clk);
        #1;
        check("reset message", message, 32'h0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset valid", {31'd0, valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < NV; t++) begin
            run_op(tbl[t], t);
        end

        // Start held high; inputs change mid-run; next capture at E0+34.
        @(negedge clk);
        drive(tbl[0]);
        start = 1'b1;
        @(posedge clk); #1;
        drive(tbl[6]);
        check("hs busy_at_E0", {31'd0, busy}, 32'd1);
        wait_valid(lat, bcnt);
        check("hs first latency", lat, 33);
        check("hs first message", message, 32'hA);
        @(posedge clk); #1;
        start = 1'b0;
        check("hs valid_at_E34", {31'd0, valid}, 32'd0);
        check("hs recapture_at_E34", {31'd0, busy}, 32'd1);
        wait_valid(lat, bcnt);
        check("hs second latency", lat, 33);
        check("hs second message", message, 32'hE);
        @(posedge clk); #1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid || busy) seen = 1'b1;
        end
        check("hs no third op", {31'd0, seen}, 32'd0);

        // Reset mid-run at E0+15.
        @(negedge clk);
        drive(tbl[0]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        check("rst busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst message", message, 32'h0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst valid", {31'd0, valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid) seen = 1'b1;
        end
        check("rst no valid after release", {31'd0, seen}, 32'd0);
        check("rst message held", message, 32'h0);

        check("busy/valid overlap count", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
